// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode width and opcode encodings shared by the ALU slice
package alu_pkg;

  localparam int OPCODE_W = 3;

  localparam logic [OPCODE_W-1:0] OP_NAND = 3'd0;
  localparam logic [OPCODE_W-1:0] OP_XOR  = 3'd1;
  localparam logic [OPCODE_W-1:0] OP_ADD  = 3'd2;
  localparam logic [OPCODE_W-1:0] OP_ASR  = 3'd3;
  localparam logic [OPCODE_W-1:0] OP_OR   = 3'd4;
  localparam logic [OPCODE_W-1:0] OP_LSL  = 3'd5;
  localparam logic [OPCODE_W-1:0] OP_NOT  = 3'd6;
  localparam logic [OPCODE_W-1:0] OP_LT   = 3'd7;

endpackage

// File: rtl/alu_register_if.sv
// rtl/alu_register_if.sv - operand/opcode/result bundle for the registered ALU
interface alu_register_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0]    first_i;
  logic [WIDTH-1:0]    second_i;
  logic [OPCODE_W-1:0] opcode_i;
  logic [WIDTH-1:0]    result_o;

  modport master (
    output first_i,
    output second_i,
    output opcode_i,
    input  result_o
  );

  modport slave (
    input  first_i,
    input  second_i,
    input  opcode_i,
    output result_o
  );

endinterface

// File: rtl/alu_core.sv
// rtl/alu_core.sv - purely combinational 8-function ALU
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]    first,
  input  logic [WIDTH-1:0]    second,
  input  logic [OPCODE_W-1:0] opcode,
  output logic [WIDTH-1:0]    result
);

  // WIDTH always fits in WIDTH bits for WIDTH >= 2
  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH[WIDTH-1:0];

  logic big_shift;
  logic [WIDTH-1:0] asr_val;
  logic [WIDTH-1:0] lsl_val;

  assign big_shift = (second >= WIDTH_V);
  assign asr_val   = big_shift ? {WIDTH{first[WIDTH-1]}}
                               : WIDTH'($signed(first) >>> second);
  assign lsl_val   = big_shift ? '0 : (first << second);

  always_comb begin
    result = '0;
    case (opcode)
      OP_NAND: result = ~(first & second);
      OP_XOR:  result = first ^ second;
      OP_ADD:  result = first + second;
      OP_ASR:  result = asr_val;
      OP_OR:   result = first | second;
      OP_LSL:  result = lsl_val;
      OP_NOT:  result = ~first;
      OP_LT:   result = {{(WIDTH-1){1'b0}}, (first < second)};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_register.sv
// rtl/alu_register.sv - ALU execute stage with one registered cycle of latency
module alu_register
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  alu_register_if.slave bus
);

  logic [WIDTH-1:0] alu_result;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .first  (bus.first_i),
    .second (bus.second_i),
    .opcode (bus.opcode_i),
    .result (alu_result)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus.result_o <= '0;
    end else begin
      bus.result_o <= alu_result;
    end
  end

endmodule

// File: tb/tb_alu_register.sv
// tb/tb_alu_register.sv - randomized self-checking bench for alu_register
module tb_alu_register;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  alu_register_if #(.WIDTH(W)) bus ();

  alu_register #(.WIDTH(W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  // Reference computed on plain integers from the operation definitions
  function automatic logic [7:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int ia, ib, sa, r;
    ia = int'(a);
    ib = int'(b);
    sa = (ia >= 128) ? ia - 256 : ia;
    case (op)
      3'd0: r = 255 - (ia & ib);
      3'd1: r = ia ^ ib;
      3'd2: r = (ia + ib) % 256;
      3'd3: r = (ib >= W) ? ((sa < 0) ? -1 : 0) : (sa >>> ib);
      3'd4: r = ia | ib;
      3'd5: r = (ib >= W) ? 0 : (ia * (1 << ib)) % 256;
      3'd6: r = 255 - ia;
      default: r = (ia < ib) ? 1 : 0;
    endcase
    return r[7:0];
  endfunction

  task automatic drive(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    bus.opcode_i = op;
    bus.first_i  = a;
    bus.second_i = b;
  endtask

  // Apply inputs at negedge, let one edge pass, sample at the following negedge
  task automatic do_op(input string tag, input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] exp);
    drive(op, a, b);
    @(negedge clk);
    check(tag, bus.result_o, exp);
  endtask

  typedef struct {
    string      tag;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [2:0] rop;
    logic [7:0] ra, rb, last;

    vecs.push_back('{"nand",    3'd0, 8'hAA, 8'hCC, 8'h77});
    vecs.push_back('{"xor",     3'd1, 8'hF0, 8'hAA, 8'h5A});
    vecs.push_back('{"add",     3'd2, 8'd100, 8'd50, 8'h96});
    vecs.push_back('{"asr",     3'd3, 8'h99, 8'd2,  8'hE6});
    vecs.push_back('{"or",      3'd4, 8'h33, 8'h55, 8'h77});
    vecs.push_back('{"lsl",     3'd5, 8'h0F, 8'd2,  8'h3C});
    vecs.push_back('{"not",     3'd6, 8'h55, 8'h13, 8'hAA});
    vecs.push_back('{"lt_yes",  3'd7, 8'd50, 8'd100, 8'h01});
    vecs.push_back('{"lt_no",   3'd7, 8'd100, 8'd50, 8'h00});
    vecs.push_back('{"lt_eq",   3'd7, 8'h80, 8'h80, 8'h00});
    vecs.push_back('{"lt_uns",  3'd7, 8'h01, 8'hFF, 8'h01});
    vecs.push_back('{"add_wrap",3'd2, 8'hFF, 8'h01, 8'h00});
    vecs.push_back('{"add_ex",  3'd2, 8'd200, 8'd100, 8'd44});
    vecs.push_back('{"asr_w",   3'd3, 8'h80, 8'd8,  8'hFF});
    vecs.push_back('{"asr_big", 3'd3, 8'h40, 8'd200, 8'h00});
    vecs.push_back('{"lsl_w",   3'd5, 8'hFF, 8'd8,  8'h00});
    vecs.push_back('{"asr_0",   3'd3, 8'hB7, 8'd0,  8'hB7});
    vecs.push_back('{"lsl_0",   3'd5, 8'hB7, 8'd0,  8'hB7});

    drive(3'd2, 8'h12, 8'h34);
    @(negedge clk);
    drive(3'd6, 8'h0F, 8'hF0);
    @(negedge clk);
    check("reset_hold", bus.result_o, 8'h00);
    rst = 1'b0;

    foreach (vecs[i]) begin
      do_op(vecs[i].tag, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
      check({vecs[i].tag, "_model"}, model(vecs[i].op, vecs[i].a, vecs[i].b), vecs[i].exp);
    end

    for (int i = 0; i < 200; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = 8'($urandom);
      rb  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 9)) : 8'($urandom);
      do_op("random", rop, ra, rb, model(rop, ra, rb));
    end

    // Reset mid-stream inside an ADD sequence; asserted between edges first
    do_op("mid_add1", 3'd2, 8'd10, 8'd20, 8'd30);
    do_op("mid_add2", 3'd2, 8'd40, 8'd50, 8'd90);
    last = bus.result_o;
    drive(3'd2, 8'd60, 8'd70);
    rst = 1'b1;
    #2;
    check("no_async", bus.result_o, 8'd90);
    @(negedge clk);
    check("mid_reset", bus.result_o, 8'h00);
    rst = 1'b0;
    do_op("post_reset", 3'd2, 8'd5, 8'd7, 8'd12);
    check("pre_reset_val", last, 8'd90);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
